// File: rtl/rf_bypass_8x16.sv
// Multi-port register file: two combinational read ports with write-through
// bypass, one write port, saturating write counter and sticky repeat-write flag.
module rf_bypass_8x16 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       read1RegSel,
  input  logic [2:0]       read2RegSel,
  input  logic [2:0]       writeRegSel,
  input  logic [WIDTH-1:0] writeData,
  input  logic             writeEn,
  output logic [WIDTH-1:0] read1Data,
  output logic [WIDTH-1:0] read2Data,
  output logic [7:0]       wrCount,
  output logic             err
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [7:0]       wr_onehot;
  logic [7:0]       wr_count_q, wr_count_d;
  logic             err_q, err_d;
  logic             hist_valid_q, hist_valid_d;
  logic [2:0]       hist_sel_q, hist_sel_d;

  always_comb begin
    wr_onehot = '0;
    if (writeEn) wr_onehot[writeRegSel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++)
        if (wr_onehot[3'(i)]) regs_q[i] <= writeData;
    end
  end

  always_comb begin
    wr_count_d   = wr_count_q;
    if (writeEn && (wr_count_q != 8'hFF)) wr_count_d = wr_count_q + 8'd1;
    // History only counts when the previous cycle also wrote.
    err_d        = err_q | (writeEn & hist_valid_q & (writeRegSel == hist_sel_q));
    hist_valid_d = writeEn;
    hist_sel_d   = writeEn ? writeRegSel : hist_sel_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count_q   <= '0;
      err_q        <= 1'b0;
      hist_valid_q <= 1'b0;
      hist_sel_q   <= '0;
    end else begin
      wr_count_q   <= wr_count_d;
      err_q        <= err_d;
      hist_valid_q <= hist_valid_d;
      hist_sel_q   <= hist_sel_d;
    end
  end

  // Bypass is independent of reset: stored copies are already zero then.
  always_comb begin
    read1Data = '0;
    read2Data = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (read1RegSel == 3'(i)) read1Data = regs_q[i];
      if (read2RegSel == 3'(i)) read2Data = regs_q[i];
    end
    if (writeEn && (writeRegSel == read1RegSel)) read1Data = writeData;
    if (writeEn && (writeRegSel == read2RegSel)) read2Data = writeData;
  end

  assign wrCount = wr_count_q;
  assign err     = err_q;

endmodule

// File: tb/tb_rf_bypass_8x16.sv
// Bench for rf_bypass_8x16: directed vector table, random traffic against a
// behavioural model, saturation and asynchronous-reset sequences.
module tb_rf_bypass_8x16;

  logic        clk;
  logic        rst;
  logic [2:0]  read1RegSel, read2RegSel, writeRegSel;
  logic [15:0] writeData;
  logic        writeEn;
  logic [15:0] read1Data, read2Data;
  logic [7:0]  wrCount;
  logic        err;

  rf_bypass_8x16 #(.WIDTH(16), .NREGS(8)) dut (
    .clk(clk), .rst(rst),
    .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
    .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn),
    .read1Data(read1Data), .read2Data(read2Data),
    .wrCount(wrCount), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Reference state: plain arrays and integers derived from the rules.
  logic [15:0] m_regs [8];
  int unsigned m_cnt;
  bit          m_err;
  bit          m_prev_we;
  int unsigned m_prev_sel;

  typedef struct {
    logic        we;
    logic [2:0]  wsel;
    logic [15:0] wdata;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [7:0]  ecnt;
    logic        eerr;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_cnt = 0; m_err = 0; m_prev_we = 0; m_prev_sel = 0;
  endtask

  task automatic model_edge(input logic we, input logic [2:0] wsel, input logic [15:0] wdata);
    if (we && m_prev_we && (int'(wsel) == m_prev_sel)) m_err = 1;
    if (we) begin
      m_regs[wsel] = wdata;
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    end
    m_prev_we  = we;
    m_prev_sel = int'(wsel);
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] r, input logic we,
                                         input logic [2:0] wsel, input logic [15:0] wdata);
    return (we && wsel == r) ? wdata : m_regs[r];
  endfunction

  task automatic drive(input logic we, input logic [2:0] wsel, input logic [15:0] wdata,
                       input logic [2:0] r1, input logic [2:0] r2);
    writeEn = we; writeRegSel = wsel; writeData = wdata;
    read1RegSel = r1; read2RegSel = r2;
  endtask

  // One clock: drive after the falling edge, check before the rising edge.
  task automatic cycle(input string tag, input logic we, input logic [2:0] wsel,
                       input logic [15:0] wdata, input logic [2:0] r1, input logic [2:0] r2);
    @(negedge clk);
    drive(we, wsel, wdata, r1, r2);
    #1;
    chk({tag, "_rd1"}, 32'(read1Data), 32'(m_read(r1, we, wsel, wdata)));
    chk({tag, "_rd2"}, 32'(read2Data), 32'(m_read(r2, we, wsel, wdata)));
    chk({tag, "_cnt"}, 32'(wrCount), m_cnt);
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    @(posedge clk);
    model_edge(we, wsel, wdata);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    model_reset();

    for (int k = 0; k < 8; k++)
      vecs[k] = '{1'b1, 3'(k), 16'(16'h1111 * k), 3'(k), 3'((k + 1) % 8),
                  16'(16'h1111 * k), 16'h0000, 8'(k), 1'b0};
    vecs[8]  = '{1'b0, 3'd3, 16'hDEAD, 3'd3, 3'd5, 16'h3333, 16'h5555, 8'd8,  1'b0};
    vecs[9]  = '{1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd4, 16'hBEEF, 16'h4444, 8'd8,  1'b0};
    vecs[10] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd7, 16'hBEEF, 16'h7777, 8'd9,  1'b0};
    vecs[11] = '{1'b1, 3'd6, 16'h0001, 3'd6, 3'd6, 16'h0001, 16'h0001, 8'd9,  1'b0};
    vecs[12] = '{1'b1, 3'd6, 16'h0002, 3'd0, 3'd6, 16'h0000, 16'h0002, 8'd10, 1'b0};
    vecs[13] = '{1'b0, 3'd6, 16'h0000, 3'd6, 3'd1, 16'h0002, 16'h1111, 8'd11, 1'b1};
    vecs[14] = '{1'b1, 3'd1, 16'h0005, 3'd6, 3'd3, 16'h0002, 16'h3333, 8'd11, 1'b1};
    vecs[15] = '{1'b0, 3'd0, 16'h0000, 3'd1, 3'd1, 16'h0005, 16'h0005, 8'd12, 1'b1};

    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Post-reset: every register reads zero on both ports.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(1'b0, 3'(k), 16'hFFFF, 3'(k), 3'(7 - k));
      #1;
      chk("rst_rd1", 32'(read1Data), 32'h0);
      chk("rst_rd2", 32'(read2Data), 32'h0);
      chk("rst_cnt", 32'(wrCount), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
    end

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wsel, vecs[i].wdata, vecs[i].r1, vecs[i].r2);
      #1;
      chk($sformatf("vec%0d_rd1", i), 32'(read1Data), 32'(vecs[i].e1));
      chk($sformatf("vec%0d_rd2", i), 32'(read2Data), 32'(vecs[i].e2));
      chk($sformatf("vec%0d_cnt", i), 32'(wrCount), 32'(vecs[i].ecnt));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].eerr));
      @(posedge clk);
      model_edge(vecs[i].we, vecs[i].wsel, vecs[i].wdata);
    end

    // Random traffic continues from the table's state.
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    // Fresh start, then 300 writes rotating through registers: counter saturates.
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cycle("sat", 1'b1, 3'(i % 8), 16'(i + 1), 3'((i + 3) % 8), 3'(i % 8));
      if (i == 254) begin
        #1;
        chk("sat_255", 32'(wrCount), 32'd255);
      end
    end
    cycle("sat_hold", 1'b0, 3'd0, 16'h0, 3'd1, 3'd2);
    chk("sat_final", 32'(wrCount), 32'd255);

    // Reset asserted mid-cycle during a write to R1: clears at once, write is lost.
    @(negedge clk);
    drive(1'b1, 3'd1, 16'hFFFF, 3'd1, 3'd3);
    #1;
    chk("arst_pre_byp", 32'(read1Data), 32'hFFFF);
    rst = 1'b0;
    #1;
    chk("arst_cnt", 32'(wrCount), 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    chk("arst_byp", 32'(read1Data), 32'hFFFF);
    chk("arst_rd2", 32'(read2Data), 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 3'd1, 16'h0, 3'd1, 3'd3);
    #1;
    chk("arst_r1", 32'(read1Data), 32'h0);
    chk("arst_cnt2", 32'(wrCount), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // First edge after release operates normally.
    cycle("post1", 1'b1, 3'd1, 16'hA5A5, 3'd1, 3'd0);
    cycle("post2", 1'b1, 3'd1, 16'h5A5A, 3'd1, 3'd1);
    cycle("post3", 1'b0, 3'd0, 16'h0, 3'd1, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
